// File: rtl/core_run_host.sv
// rtl/core_run_host.sv - host-side req/done run sequencer for the processor core (optional CORE_RUN_HOST_MAXCYC_EN adds max_cycles)
module core_run_host #(
    parameter int CW      = 16,
    parameter int REQ_LEN = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    num_runs,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic [3:0]    runs_done,
    output logic [CW-1:0] last_cycles,
`ifdef CORE_RUN_HOST_MAXCYC_EN
    output logic [CW-1:0] max_cycles,
`endif
    output logic          timeout_err,
    output logic          finished
);
    localparam int RW = $clog2(REQ_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FIN,
        ERR
    } state_t;

    state_t        state_q;
    logic [RW-1:0] req_cnt_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    num_q;
    logic          core_req_q;
    logic          busy_q;
    logic [3:0]    runs_done_q;
    logic [CW-1:0] last_cycles_q;
    logic          timeout_err_q;
    logic          finished_q;
    logic [3:0]    runs_next;
`ifdef CORE_RUN_HOST_MAXCYC_EN
    logic [CW-1:0] max_cycles_q;
`endif

    // Run count as it will be once the current run is credited
    assign runs_next = runs_done_q + 4'd1;

    // Batch sequencer: every output is a register written here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_cnt_q     <= '0;
            cnt_q         <= '0;
            num_q         <= '0;
            core_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            runs_done_q   <= '0;
            last_cycles_q <= '0;
            timeout_err_q <= 1'b0;
            finished_q    <= 1'b0;
`ifdef CORE_RUN_HOST_MAXCYC_EN
            max_cycles_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Any accepted start begins a fresh batch record
                        num_q         <= num_runs;
                        runs_done_q   <= '0;
                        last_cycles_q <= '0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
`ifdef CORE_RUN_HOST_MAXCYC_EN
                        max_cycles_q  <= '0;
`endif
                        if (num_runs != 4'd0) begin
                            state_q    <= REQ;
                            req_cnt_q  <= RW'(REQ_LEN);
                            core_req_q <= 1'b1;
                        end else begin
                            state_q    <= FIN;
                            finished_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // core_done is deliberately ignored here, masking a stale done
                    if (req_cnt_q == RW'(1)) begin
                        state_q    <= WAIT;
                        core_req_q <= 1'b0;
                        cnt_q      <= CW'(1);
                    end else begin
                        req_cnt_q <= req_cnt_q - RW'(1);
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        last_cycles_q <= cnt_q;
                        runs_done_q   <= runs_next;
`ifdef CORE_RUN_HOST_MAXCYC_EN
                        if (cnt_q > max_cycles_q) begin
                            max_cycles_q <= cnt_q;
                        end
`endif
                        if (runs_next == num_q) begin
                            state_q    <= FIN;
                            finished_q <= 1'b1;
                        end else begin
                            // Back-to-back: req rises on the very next cycle
                            state_q    <= REQ;
                            req_cnt_q  <= RW'(REQ_LEN);
                            core_req_q <= 1'b1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_q       <= ERR;
                        timeout_err_q <= 1'b1;
                        finished_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIN, ERR: begin
                    state_q    <= IDLE;
                    finished_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    core_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_req    = core_req_q;
    assign busy        = busy_q;
    assign runs_done   = runs_done_q;
    assign last_cycles = last_cycles_q;
    assign timeout_err = timeout_err_q;
    assign finished    = finished_q;
`ifdef CORE_RUN_HOST_MAXCYC_EN
    assign max_cycles  = max_cycles_q;
`endif

endmodule

// File: tb/tb_core_run_host.sv
// tb/tb_core_run_host.sv - self-checking bench for core_run_host
module tb_core_run_host;
    localparam int CW      = 16;
    localparam int REQ_LEN = 2;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 500;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    num_runs = 4'd0;
    logic          core_req;
    logic          core_done = 1'b0;
    logic          busy;
    logic [3:0]    runs_done;
    logic [CW-1:0] last_cycles;
`ifdef CORE_RUN_HOST_MAXCYC_EN
    logic [CW-1:0] max_cycles;
`endif
    logic          timeout_err;
    logic          finished;

    int checks = 0;
    int failures = 0;

    // Core model state and per-batch observations
    int lats [8];
    int ri, wcnt;
    bit in_wait, prev_req, hold_done;
    int busy_cyc, req_cyc, fin_cnt;

    core_run_host #(.CW(CW), .REQ_LEN(REQ_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_runs   (num_runs),
        .core_req   (core_req),
        .core_done  (core_done),
        .busy       (busy),
        .runs_done  (runs_done),
        .last_cycles(last_cycles),
`ifdef CORE_RUN_HOST_MAXCYC_EN
        .max_cycles (max_cycles),
`endif
        .timeout_err(timeout_err),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, record outputs, and let the core model respond.
    // The core raises done during its L-th cycle after req falls, so done is sampled at WAIT edge L.
    task automatic step();
        @(negedge clk);
        if (busy === 1'b1) busy_cyc++;
        if (core_req === 1'b1) req_cyc++;
        if (finished === 1'b1) fin_cnt++;
        if (core_done && in_wait) begin
            ri++;
            in_wait = 1'b0;
        end
        if (core_req) begin
            in_wait = 1'b0;
            wcnt = 0;
        end else if (prev_req) begin
            in_wait = 1'b1;
            wcnt = 1;
        end else if (in_wait) begin
            wcnt++;
        end
        prev_req = core_req;
        core_done = hold_done || (in_wait && !core_req && ri < 8 && wcnt == lats[ri]);
    endtask

    // Launch a batch of n runs using lats[], optionally poking start while busy, then check results.
    task automatic run_batch(input int n, input bit poke);
        int attempted, completed, exp_busy, exp_last, exp_max, c;
        bit tmo;
        in_wait = 1'b0; ri = 0; prev_req = 1'b0; wcnt = 0;
        busy_cyc = 0; req_cyc = 0; fin_cnt = 0;
        start = 1'b1;
        num_runs = 4'(n);
        step();
        start = 1'b0;
        num_runs = 4'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        chk("terr_cleared", 32'(timeout_err), 0);
        chk("runs_cleared", 32'(runs_done), 0);
        if (n == 0) chk("zero_fin_next", 32'(finished), 1);
        c = 0;
        while (c < 2000 && !(fin_cnt > 0 && busy === 1'b0)) begin
            if (poke && c == 1) begin
                start = 1'b1;
                num_runs = 4'hf;
            end
            step();
            start = 1'b0;
            c++;
        end
        chk("batch_in_budget", 32'(c < 2000), 1);

        attempted = 0; completed = 0; exp_last = 0; exp_max = 0; tmo = 1'b0;
        exp_busy = 1;
        for (int i = 0; i < n; i++) begin
            attempted++;
            if (lats[i] <= TIMEOUT) begin
                completed++;
                exp_busy += REQ_LEN + lats[i];
                exp_last = lats[i];
                if (lats[i] > exp_max) exp_max = lats[i];
            end else begin
                exp_busy += REQ_LEN + TIMEOUT;
                tmo = 1'b1;
                break;
            end
        end
        chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
        chk("req_cycles", 32'(req_cyc), 32'(REQ_LEN * attempted));
        chk("fin_pulses", 32'(fin_cnt), 1);
        chk("runs_done", 32'(runs_done), 32'(completed));
        chk("last_cycles", 32'(last_cycles), 32'(exp_last));
        chk("timeout_err", 32'(timeout_err), 32'(tmo));
`ifdef CORE_RUN_HOST_MAXCYC_EN
        chk("max_cycles", 32'(max_cycles), 32'(exp_max));
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lats[i] = 1;
        ri = 0; wcnt = 0; in_wait = 1'b0; prev_req = 1'b0; hold_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(core_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_runs", 32'(runs_done), 0);
        chk("rst_last", 32'(last_cycles), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_fin", 32'(finished), 0);
`ifdef CORE_RUN_HOST_MAXCYC_EN
        chk("rst_max", 32'(max_cycles), 0);
`endif
        reset = 1'b1;
        step();

        // Single run, done at 5th WAIT cycle
        lats[0] = 5;
        run_batch(1, 1'b0);

        // Batch of three with latencies 4, 9, 2, start poked while busy
        lats[0] = 4; lats[1] = 9; lats[2] = 2;
        run_batch(3, 1'b1);

        // Timeout on the first of two runs
        lats[0] = NEVER; lats[1] = NEVER;
        run_batch(2, 1'b0);

        // Zero runs (also clears the previous timeout)
        run_batch(0, 1'b0);

        // Stale done held high from the previous batch into a new one
        hold_done = 1'b1;
        repeat (2) step();
        lats[0] = 1;
        run_batch(1, 1'b0);
        hold_done = 1'b0;
        step();

        // Reset mid-REQ drops req and busy asynchronously
        start = 1'b1;
        num_runs = 4'd3;
        step();
        start = 1'b0;
        chk("pre_rst_req", 32'(core_req), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(core_req), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_runs", 32'(runs_done), 0);

        // Randomized batches
        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) begin
                lats[i] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, TIMEOUT);
            end
            run_batch(n, (n != 0) && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
